// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: PC, single-outstanding imem requests,
// small instruction FIFO with valid/ready delivery, redirect/flush.
// Ports:
//   clk, rst_n (async, active-low)
//   imem_req/imem_addr/imem_gnt : request channel
//   imem_rvalid/imem_rdata      : response channel
//   instr_valid/instr_ready     : decode handshake
//   instr/opcode/instr_pc/pc_plus4 : head of FIFO
//   redirect/redirect_pc        : flush and restart fetch
// Optional: FETCH_PERF_EN adds fetch_cnt / drop_cnt counters.
module instr_fetch_unit #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int                BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [DATA_W-1:0] imem_rdata,
    output logic              instr_valid,
    input  logic              instr_ready,
    output logic [DATA_W-1:0] instr,
    output logic [5:0]        opcode,
    output logic [ADDR_W-1:0] instr_pc,
    output logic [ADDR_W-1:0] pc_plus4,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]       fetch_cnt,
    output logic [15:0]       drop_cnt
`endif
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] REQ  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;

    localparam int PW = $clog2(BUF_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] DEPTH = CW'(BUF_DEPTH);

    logic [1:0]        state, state_n;
    logic [ADDR_W-1:0] pc, pc_n;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W-1:0] tgt;
    logic              drop, drop_n;
    logic [CW-1:0]     count, count_n;
    logic [PW-1:0]     rd_ptr, wr_ptr;
    logic              rsp, push, pop;

    logic [ADDR_W+DATA_W-1:0] fifo_q [BUF_DEPTH];
    logic [ADDR_W+DATA_W-1:0] head;

    assign tgt  = redirect_pc & ~ADDR_W'(3);
    assign rsp  = (state == WAIT) && imem_rvalid;
    assign push = rsp && !drop && !redirect;
    assign pop  = instr_valid && instr_ready && !redirect;

    assign imem_req    = (state == REQ);
    assign imem_addr   = addr_q;
    assign instr_valid = (count != '0);

    assign head     = fifo_q[rd_ptr];
    assign instr    = instr_valid ? head[DATA_W-1:0] : '0;
    assign instr_pc = instr_valid ? head[ADDR_W+DATA_W-1:DATA_W] : '0;
    assign pc_plus4 = instr_valid ? instr_pc + ADDR_W'(4) : '0;
    assign opcode   = instr[DATA_W-1 -: 6];

    always_comb begin
        if (redirect)
            count_n = '0;
        else
            count_n = count + CW'(push) - CW'(pop);
    end

    // pc is the next address to fetch; a wrong-path grant
    // (drop set) must not advance it past a redirect target.
    always_comb begin
        state_n = state;
        pc_n    = pc;
        drop_n  = drop;
        if (redirect)
            pc_n = tgt;
        unique case (state)
            IDLE: begin
                if (redirect || count < DEPTH)
                    state_n = REQ;
            end
            REQ: begin
                if (redirect)
                    drop_n = 1'b1;
                if (imem_gnt) begin
                    state_n = WAIT;
                    if (!redirect && !drop)
                        pc_n = pc + ADDR_W'(4);
                end
            end
            WAIT: begin
                if (imem_rvalid) begin
                    drop_n  = 1'b0;
                    state_n = (count_n < DEPTH) ? REQ : IDLE;
                end else if (redirect) begin
                    drop_n = 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            pc     <= RESET_PC;
            addr_q <= RESET_PC;
            drop   <= 1'b0;
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
        end else begin
            state <= state_n;
            pc    <= pc_n;
            drop  <= drop_n;
            count <= count_n;
            if (state_n == REQ && state != REQ)
                addr_q <= pc_n;
            if (redirect) begin
                rd_ptr <= '0;
                wr_ptr <= '0;
            end else begin
                if (push)
                    wr_ptr <= wr_ptr + PW'(1);
                if (pop)
                    rd_ptr <= rd_ptr + PW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            fifo_q[wr_ptr] <= {addr_q, imem_rdata};
    end

`ifdef FETCH_PERF_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_cnt <= '0;
            drop_cnt  <= '0;
        end else begin
            if (pop)
                fetch_cnt <= fetch_cnt + 32'd1;
            if (rsp && (drop || redirect))
                drop_cnt <= drop_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit with a grant-time scoreboard
// and a small imem model (zero or one extra wait cycle).
module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [31:0] instr_pc;
    logic [31:0] pc_plus4;
    logic        redirect;
    logic [31:0] redirect_pc;
`ifdef FETCH_PERF_EN
    logic [31:0] fetch_cnt;
    logic [15:0] drop_cnt;
    logic [31:0] fc_save;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] data;
    } ent_t;

    ent_t        q[$];
    logic [31:0] exp_fetch;
    logic        skip;
    int          checks;
    int          errors;

    logic        mem_rv;
    logic [31:0] mem_rd;
    logic        busy;
    logic [31:0] paddr;
    int          wcnt;
    int          extra;
    logic        stale_rv;

    instr_fetch_unit dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .opcode      (opcode),
        .instr_pc    (instr_pc),
        .pc_plus4    (pc_plus4),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
`ifdef FETCH_PERF_EN
        ,
        .fetch_cnt   (fetch_cnt),
        .drop_cnt    (drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] word(logic [31:0] a);
        return 32'h2008_0005 ^ {6'd0, a[27:2]};
    endfunction

    assign imem_gnt    = imem_req;
    assign imem_rvalid = mem_rv | stale_rv;
    assign imem_rdata  = mem_rv ? mem_rd : 32'hBAD0_BAD0;

    always @(posedge clk) begin
        mem_rv <= 1'b0;
        if (busy) begin
            if (wcnt == 0) begin
                mem_rv <= 1'b1;
                mem_rd <= word(paddr);
                busy   <= 1'b0;
            end else begin
                wcnt <= wcnt - 1;
            end
        end
        if (imem_req && imem_gnt) begin
            if (extra == 0) begin
                mem_rv <= 1'b1;
                mem_rd <= word(imem_addr);
            end else begin
                busy  <= 1'b1;
                paddr <= imem_addr;
                wcnt  <= extra - 1;
            end
        end
        if (!rst_n) begin
            busy   <= 1'b0;
            mem_rv <= 1'b0;
        end
    end

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic monitor();
        ent_t e;
        if (!rst_n) begin
            q.delete();
            exp_fetch = 32'h0;
            skip = 1'b0;
            return;
        end
        if (instr_valid && instr_ready && !redirect) begin
            if (q.size() == 0) begin
                chk("sb_underflow", 32'(q.size()), 32'd1);
            end else begin
                e = q.pop_front();
                chk("sb_pc", instr_pc, e.pc);
                chk("sb_instr", instr, e.data);
                chk("sb_pc4", pc_plus4, e.pc + 32'd4);
                chk("sb_opcode", {26'd0, opcode}, {26'd0, e.data[31:26]});
            end
        end
        if (redirect) begin
            q.delete();
            exp_fetch = {redirect_pc[31:2], 2'b00};
            skip = imem_req && !imem_gnt;
        end else if (imem_req && imem_gnt) begin
            if (skip) begin
                skip = 1'b0;
            end else begin
                chk("fetch_addr", imem_addr, exp_fetch);
                q.push_back('{exp_fetch, word(exp_fetch)});
                exp_fetch = exp_fetch + 32'd4;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
    endtask

    task automatic find_grant();
        for (int n = 0; n < 20 && !(imem_req && imem_gnt); n++)
            tick();
        chk("grant_seen", {31'd0, imem_req && imem_gnt}, 32'd1);
    endtask

    task automatic find_valid();
        for (int n = 0; n < 20 && !instr_valid; n++)
            tick();
        chk("valid_seen", {31'd0, instr_valid}, 32'd1);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        busy = 1'b0;
        mem_rv = 1'b0;
        mem_rd = '0;
        paddr = '0;
        wcnt = 0;
        extra = 0;
        stale_rv = 1'b0;
        exp_fetch = '0;
        skip = 1'b0;
        rst_n = 1'b0;
        instr_ready = 1'b0;
        redirect = 1'b0;
        redirect_pc = '0;

        tick();
        tick();
        chk("rst_valid", {31'd0, instr_valid}, 32'd0);
        chk("rst_req", {31'd0, imem_req}, 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_pc", instr_pc, 32'h0);
        chk("rst_pc4", pc_plus4, 32'h0);
`ifdef FETCH_PERF_EN
        chk("rst_fcnt", fetch_cnt, 32'd0);
        chk("rst_dcnt", {16'd0, drop_cnt}, 32'd0);
`endif

        // cycle 1 after release is IDLE; head appears in cycle 4
        rst_n = 1'b1;
        tick();
        chk("c2_req", {31'd0, imem_req}, 32'd1);
        chk("c2_addr", imem_addr, 32'h0);
        tick();
        chk("c3_valid", {31'd0, instr_valid}, 32'd0);
        tick();
        chk("c4_valid", {31'd0, instr_valid}, 32'd1);
        chk("c4_instr", instr, 32'h2008_0005);
        chk("c4_opcode", {26'd0, opcode}, 32'd8);
        chk("c4_pc", instr_pc, 32'h0);
        chk("c4_pc4", pc_plus4, 32'h4);

        // backpressure: FIFO fills to two, fetch stops
        for (int i = 0; i < 10; i++)
            tick();
        chk("bp_req", {31'd0, imem_req}, 32'd0);
        chk("bp_valid", {31'd0, instr_valid}, 32'd1);
        chk("bp_head", instr_pc, 32'h0);
        instr_ready = 1'b1;
        tick();
        chk("bp_head2", instr_pc, 32'h4);
        chk("bp_req2", {31'd0, imem_req}, 32'd0);
        tick();
        chk("bp_empty", {31'd0, instr_valid}, 32'd0);
        chk("bp_req3", {31'd0, imem_req}, 32'd1);
        chk("bp_addr3", imem_addr, 32'h8);
        for (int i = 0; i < 6; i++)
            tick();

        // redirect while waiting on a slow response
        extra = 1;
        find_grant();
        tick();
        chk("rd_pre_rv", {31'd0, imem_rvalid}, 32'd0);
        redirect = 1'b1;
        redirect_pc = 32'h0000_0103;
        tick();
        redirect = 1'b0;
        chk("rd_flush", {31'd0, instr_valid}, 32'd0);
        chk("rd_req_hold", {31'd0, imem_req}, 32'd0);
        tick();
        chk("rd_req", {31'd0, imem_req}, 32'd1);
        chk("rd_addr", imem_addr, 32'h100);
        chk("rd_nopush", {31'd0, instr_valid}, 32'd0);
        find_valid();
        chk("rd_head", instr_pc, 32'h100);
`ifdef FETCH_PERF_EN
        chk("rd_dcnt", {16'd0, drop_cnt}, 32'd1);
`endif

        // redirect coinciding with rvalid and an accepted head
        instr_ready = 1'b0;
        extra = 0;
        find_grant();
        tick();
        chk("rr_rv", {31'd0, imem_rvalid}, 32'd1);
        chk("rr_valid", {31'd0, instr_valid}, 32'd1);
`ifdef FETCH_PERF_EN
        fc_save = fetch_cnt;
`endif
        instr_ready = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'h0000_0200;
        tick();
        redirect = 1'b0;
        chk("rr_valid2", {31'd0, instr_valid}, 32'd0);
        chk("rr_req", {31'd0, imem_req}, 32'd1);
        chk("rr_addr", imem_addr, 32'h200);
`ifdef FETCH_PERF_EN
        chk("rr_fcnt", fetch_cnt, fc_save);
        chk("rr_dcnt", {16'd0, drop_cnt}, 32'd2);
`endif
        for (int i = 0; i < 6; i++)
            tick();

        // PC wrap at the top of the address space
        redirect = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        tick();
        redirect = 1'b0;
        find_valid();
        chk("wr_pc", instr_pc, 32'hFFFF_FFFC);
        chk("wr_pc4", pc_plus4, 32'h0);
        chk("wr_req", {31'd0, imem_req}, 32'd1);
        chk("wr_addr", imem_addr, 32'h0);
        for (int i = 0; i < 6; i++)
            tick();

        // reset pulse while a granted request is outstanding
        extra = 1;
        find_grant();
        tick();
        rst_n = 1'b0;
        #1;
        chk("ar_valid", {31'd0, instr_valid}, 32'd0);
        chk("ar_req", {31'd0, imem_req}, 32'd0);
        tick();
        rst_n = 1'b1;
        extra = 0;
        stale_rv = 1'b1;
        tick();
        stale_rv = 1'b0;
        chk("ar_stale", {31'd0, instr_valid}, 32'd0);
        chk("ar_req2", {31'd0, imem_req}, 32'd1);
        chk("ar_addr", imem_addr, 32'h0);
        find_valid();
        chk("ar_head", instr_pc, 32'h0);
        for (int i = 0; i < 8; i++)
            tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
